// File: rtl/dram_arb_pkg.sv
// +--------------------------------------------------------------------+
// | dram_arb_pkg : shared op codes and FSM states for the DRAM arbiter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package dram_arb_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_CPU     = 2'b01,
    OP_DMA     = 2'b10,
    OP_REFRESH = 2'b11
  } dram_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dram_refresh_timer.sv
// +--------------------------------------------------------------------+
// | dram_refresh_timer : refresh interval timer and pending backlog    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 512,
  parameter int MAX_PENDING      = 4,
  parameter int URGENT_LEVEL     = 2
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic       refTaken,
  output logic [2:0] refPending,
  output logic       refUrgent,
  output logic       refOverrun
);

  localparam int            TW   = $clog2(REFRESH_INTERVAL);
  localparam logic [TW-1:0] TERM = TW'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]    MAXP = 3'(MAX_PENDING);
  localparam logic [2:0]    URG  = 3'(URGENT_LEVEL);

  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic          tick;

  always_comb begin
    tick      = (timer_q == TERM);
    timer_d   = tick ? '0 : timer_q + TW'(1);
    pending_d = pending_q;
    overrun_d = overrun_q;
    // A tick and a refresh start in the same clock cancel out.
    if (tick && !refTaken) begin
      if (pending_q == MAXP) overrun_d = 1'b1;
      else                   pending_d = pending_q + 3'd1;
    end else if (refTaken && !tick) begin
      pending_d = pending_q - 3'd1;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      timer_q   <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign refPending = pending_q;
  assign refUrgent  = (pending_q >= URG);
  assign refOverrun = overrun_q;

endmodule

`default_nettype wire

// File: rtl/dram_arbiter.sv
// +--------------------------------------------------------------------+
// | dram_arbiter : shares the DRAM sequencer among CPU, DMA, refresh   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 512,
  parameter int MAX_PENDING      = 4,
  parameter int URGENT_LEVEL     = 2,
  parameter int DMA_STARVE_LIMIT = 4,
  parameter int RECOVER_CYCLES   = 1
) (
  input  logic       clock,
  input  logic       nReset,
  input  logic       cpuReq,
  input  logic       dmaReq,
  input  logic       seqDone,
  output logic       seqStart,
  output dram_op_t   seqOp,
  output logic       cpuGnt,
  output logic       dmaGnt,
  output logic [2:0] refPending,
  output logic       refOverrun
);

  localparam int            SW       = $clog2(DMA_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(DMA_STARVE_LIMIT);
  localparam int            RW       = (RECOVER_CYCLES < 2) ? 1 : $clog2(RECOVER_CYCLES);
  localparam logic [RW-1:0] REC_LAST = RW'((RECOVER_CYCLES == 0) ? 0 : RECOVER_CYCLES - 1);

  arb_state_t    state_q, state_d;
  dram_op_t      op_q, op_d, winner;
  logic          start_q, start_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          dma_gnt_q, dma_gnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [RW-1:0] rec_q, rec_d;
  logic          ref_taken;
  logic          ref_urgent;

  dram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_PENDING      (MAX_PENDING),
    .URGENT_LEVEL     (URGENT_LEVEL)
  ) u_refresh (
    .clock      (clock),
    .nReset     (nReset),
    .refTaken   (ref_taken),
    .refPending (refPending),
    .refUrgent  (ref_urgent),
    .refOverrun (refOverrun)
  );

  always_comb begin
    if (ref_urgent)                           winner = OP_REFRESH;
    else if (dmaReq && starve_q >= STARVE_MAX) winner = OP_DMA;
    else if (cpuReq)                          winner = OP_CPU;
    else if (dmaReq)                          winner = OP_DMA;
    else if (refPending != 3'd0)              winner = OP_REFRESH;
    else                                      winner = OP_NONE;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    start_d   = 1'b0;
    cpu_gnt_d = cpu_gnt_q;
    dma_gnt_d = dma_gnt_q;
    rec_d     = rec_q;
    ref_taken = 1'b0;
    case (state_q)
      IDLE: begin
        if (winner != OP_NONE) begin
          start_d   = 1'b1;
          op_d      = winner;
          cpu_gnt_d = (winner == OP_CPU);
          dma_gnt_d = (winner == OP_DMA);
          ref_taken = (winner == OP_REFRESH);
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (seqDone) begin
          op_d      = OP_NONE;
          cpu_gnt_d = 1'b0;
          dma_gnt_d = 1'b0;
          rec_d     = '0;
          state_d   = (RECOVER_CYCLES == 0) ? IDLE : RECOVER;
        end
      end
      RECOVER: begin
        if (rec_q == REC_LAST) state_d = IDLE;
        else                   rec_d   = rec_q + RW'(1);
      end
      default: begin
        state_d   = IDLE;
        op_d      = OP_NONE;
        cpu_gnt_d = 1'b0;
        dma_gnt_d = 1'b0;
      end
    endcase

    // Starvation only accumulates while DMA is actually waiting.
    starve_d = starve_q;
    if (!dmaReq) begin
      starve_d = '0;
    end else if (state_q == IDLE && winner == OP_DMA) begin
      starve_d = '0;
    end else if (state_q == IDLE && winner == OP_CPU && starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      op_q      <= OP_NONE;
      start_q   <= 1'b0;
      cpu_gnt_q <= 1'b0;
      dma_gnt_q <= 1'b0;
      starve_q  <= '0;
      rec_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      start_q   <= start_d;
      cpu_gnt_q <= cpu_gnt_d;
      dma_gnt_q <= dma_gnt_d;
      starve_q  <= starve_d;
      rec_q     <= rec_d;
    end
  end

  assign seqStart = start_q;
  assign seqOp    = op_q;
  assign cpuGnt   = cpu_gnt_q;
  assign dmaGnt   = dma_gnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_dram_arbiter : self-checking bench for dram_arbiter             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dram_arbiter;

  localparam int RI   = 16;
  localparam int MAXP = 4;
  localparam int URG  = 2;
  localparam int LIM  = 4;
  localparam int RC   = 1;

  logic       clock = 1'b0;
  logic       nReset = 1'b0;
  logic       cpuReq = 1'b0, dmaReq = 1'b0, seqDone = 1'b0;
  logic       seqStart, cpuGnt, dmaGnt, refOverrun;
  logic [1:0] seqOp;
  logic [2:0] refPending;

  int checks = 0;
  int errors = 0;

  dram_arbiter #(
    .REFRESH_INTERVAL (RI),
    .MAX_PENDING      (MAXP),
    .URGENT_LEVEL     (URG),
    .DMA_STARVE_LIMIT (LIM),
    .RECOVER_CYCLES   (RC)
  ) dut (
    .clock      (clock),
    .nReset     (nReset),
    .cpuReq     (cpuReq),
    .dmaReq     (dmaReq),
    .seqDone    (seqDone),
    .seqStart   (seqStart),
    .seqOp      (seqOp),
    .cpuGnt     (cpuGnt),
    .dmaGnt     (dmaGnt),
    .refPending (refPending),
    .refOverrun (refOverrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clock) begin
    if (nReset) begin
      check("gnt_exclusive", 32'(cpuGnt & dmaGnt), 32'd0);
      check("pending_bound", 32'(refPending > 3'(MAXP)), 32'd0);
    end
  end

  // Sequencer stand-in: seqDone is sampled on the 4th edge after seqStart.
  bit auto_seq = 0;
  bit hold_seq = 0;
  int seq_cnt  = 0;

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
    if (auto_seq) begin
      seqDone = 1'b0;
      if (seq_cnt > 0) seq_cnt++;
      if (seqStart) seq_cnt = 1;
      if (seq_cnt >= 4 && !hold_seq) begin
        seqDone = 1'b1;
        seq_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    nReset = 1'b0;
    cpuReq = 1'b0; dmaReq = 1'b0; seqDone = 1'b0;
    auto_seq = 0; hold_seq = 0; seq_cnt = 0;
    repeat (2) @(negedge clock);
    nReset = 1'b1;
  endtask

  // Reference model: arbitration expressed directly from the priority rules.
  int m_phase, m_op, m_rec, m_timer, m_backlog, m_starve;
  bit m_start, m_ovr;

  task automatic model_reset();
    m_phase = 0; m_op = 0; m_rec = 0; m_timer = 0;
    m_backlog = 0; m_starve = 0; m_start = 0; m_ovr = 0;
  endtask

  function automatic int pick();
    if (m_backlog >= URG)          return 3;
    if (dmaReq && m_starve >= LIM) return 2;
    if (cpuReq)                    return 1;
    if (dmaReq)                    return 2;
    if (m_backlog > 0)             return 3;
    return 0;
  endfunction

  task automatic model_step();
    bit tick, taken;
    int win;
    tick  = (m_timer == RI - 1);
    taken = 0;
    win   = pick();
    m_timer = tick ? 0 : m_timer + 1;
    m_start = 0;
    if (!dmaReq) m_starve = 0;
    else if (m_phase == 0 && win == 2) m_starve = 0;
    else if (m_phase == 0 && win == 1 && m_starve < LIM) m_starve++;
    if (m_phase == 0) begin
      if (win != 0) begin
        m_start = 1; m_op = win; m_phase = 1; taken = (win == 3);
      end
    end else if (m_phase == 1) begin
      if (seqDone) begin
        m_op = 0;
        if (RC == 0) m_phase = 0;
        else begin m_phase = 2; m_rec = RC; end
      end
    end else begin
      m_rec--;
      if (m_rec == 0) m_phase = 0;
    end
    if (tick && !taken) begin
      if (m_backlog == MAXP) m_ovr = 1;
      else m_backlog++;
    end else if (taken && !tick) begin
      m_backlog--;
    end
  endtask

  typedef struct packed {
    bit       cpu, dma, done;
    bit       e_start;
    bit [1:0] e_op;
    bit       e_cg, e_dg;
    bit [2:0] e_pend;
  } vec_t;

  vec_t tbl[13];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, ref_starts, maxp;
    bit cpu_at_b1;
    logic [1:0] wins[5];
    logic [1:0] exp_wins[5];
    logic [8:0] exp_v, act_v;

    exp_wins = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

    //            cpu dma done  st  op  cg dg pend
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 3'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 3'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};

    // Reset state
    do_reset();
    check("reset_outputs", {25'd0, seqStart, seqOp, cpuGnt, dmaGnt, refPending, refOverrun}, 32'd0);

    // Cycle-by-cycle vectors: CPU cycle, recover, early done, DMA cycle, stray seqDone
    for (int i = 0; i < 13; i++) begin
      cpuReq = tbl[i].cpu; dmaReq = tbl[i].dma; seqDone = tbl[i].done;
      @(posedge clock);
      @(negedge clock);
      check($sformatf("vec%0d", i), {24'd0, seqStart, seqOp, cpuGnt, dmaGnt, refPending},
            {24'd0, tbl[i].e_start, tbl[i].e_op, tbl[i].e_cg, tbl[i].e_dg, tbl[i].e_pend});
    end
    seqDone = 1'b0; cpuReq = 1'b0; dmaReq = 1'b0;

    // Idle refresh: first tick after 16 clocks, then an opportunistic refresh
    do_reset();
    repeat (16) cycle();
    check("t3_pending1", 32'(refPending), 32'd1);
    check("t3_no_start", 32'(seqStart), 32'd0);
    cycle();
    check("t3_ref_start", {29'd0, seqStart, seqOp}, {29'd0, 1'b1, 2'd3});
    check("t3_no_grant", {30'd0, cpuGnt, dmaGnt}, 32'd0);
    check("t3_pending0", 32'(refPending), 32'd0);

    // CPU and DMA both held: four CPU wins, then forced DMA
    do_reset();
    auto_seq = 1; cpuReq = 1'b1; dmaReq = 1'b1;
    n = 0;
    for (int c = 0; c < 300 && n < 5; c++) begin
      cycle();
      if (seqStart && seqOp != 2'd3) begin
        wins[n] = seqOp;
        if (seqOp == 2'd2) check("t2_starve_clear", 32'(dut.starve_q), 32'd0);
        n++;
      end
    end
    check("t2_win_count", 32'(n), 32'd5);
    for (int k = 0; k < 5; k++) check($sformatf("t2_win%0d", k), 32'(wins[k]), 32'(exp_wins[k]));

    // CPU held 40 clocks: CPU beats backlog 1, refresh takes backlog 2
    do_reset();
    auto_seq = 1; cpuReq = 1'b1;
    ref_starts = 0; maxp = 0; cpu_at_b1 = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (int'(refPending) > maxp) maxp = int'(refPending);
      if (seqStart && seqOp == 2'd3) ref_starts++;
      if (seqStart && seqOp == 2'd1 && refPending == 3'd1) cpu_at_b1 = 1;
    end
    check("t4_cpu_at_b1", 32'(cpu_at_b1), 32'd1);
    check("t4_ref_taken", 32'(ref_starts > 0), 32'd1);
    check("t4_max_pending", 32'(maxp), 32'd2);
    cpuReq = 1'b0;

    // Sequencer stalled: backlog saturates, overrun is sticky
    do_reset();
    auto_seq = 1; hold_seq = 1; cpuReq = 1'b1;
    cycle();
    cpuReq = 1'b0;
    repeat (80) cycle();
    check("t5_saturate", 32'(refPending), 32'd4);
    check("t5_overrun", 32'(refOverrun), 32'd1);
    check("t5_gnt_kept", 32'(cpuGnt), 32'd1);
    hold_seq = 0;
    for (int c = 0; c < 300 && refPending != 3'd0; c++) cycle();
    check("t5_drained", 32'(refPending), 32'd0);
    check("t5_overrun_sticky", 32'(refOverrun), 32'd1);

    // Asynchronous reset mid-cycle
    do_reset();
    auto_seq = 1; hold_seq = 1; cpuReq = 1'b1;
    repeat (20) cycle();
    check("t6_pre_gnt", {29'd0, cpuGnt, refPending[1:0]}, {29'd0, 1'b1, 2'd1});
    #2 nReset = 1'b0;
    #1;
    check("t6_async_gnt", 32'(cpuGnt), 32'd0);
    check("t6_async_pend", 32'(refPending), 32'd0);
    check("t6_async_op", 32'(seqOp), 32'd0);
    @(negedge clock);
    hold_seq = 0; seq_cnt = 0;
    nReset = 1'b1;
    cycle();
    check("t6_restart", {29'd0, seqStart, seqOp}, {29'd0, 1'b1, 2'd1});
    check("t6_regrant", 32'(cpuGnt), 32'd1);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      exp_v = {m_start, 2'(m_op), (m_phase == 1 && m_op == 1), (m_phase == 1 && m_op == 2),
               3'(m_backlog), m_ovr};
      act_v = {seqStart, seqOp, cpuGnt, dmaGnt, refPending, refOverrun};
      check($sformatf("rand%0d", i), 32'(act_v), 32'(exp_v));
      cpuReq  = 1'($urandom_range(0, 1));
      dmaReq  = 1'($urandom_range(0, 1));
      seqDone = ($urandom_range(0, (i < 750) ? 3 : 40) == 0);
      model_step();
      @(posedge clock);
      @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
